// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one instruction fetch at a time,
// and presents fetched instructions to decode through a stallable slot.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] pc,
  output logic        misaligned
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] hold_data;
  logic        consume;
  logic        slot_free;

  assign consume   = if_valid & ~stall;
  assign slot_free = ~if_valid | consume;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Redirect outranks everything; which state follows depends on whether a
  // stale request is left outstanding that must be drained.
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      unique case (state)
        REQ:     state_nxt = imem_req_ready ? DRAIN : REQ;
        WAIT:    state_nxt = imem_rsp_valid ? REQ : DRAIN;
        DRAIN:   state_nxt = imem_rsp_valid ? REQ : DRAIN;
        default: state_nxt = REQ;
      endcase
    end else begin
      unique case (state)
        IDLE:    state_nxt = REQ;
        REQ:     if (imem_req_ready) state_nxt = WAIT;
        WAIT:    if (imem_rsp_valid) state_nxt = slot_free ? REQ : HOLD;
        HOLD:    if (consume) state_nxt = REQ;
        DRAIN:   if (imem_rsp_valid) state_nxt = REQ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = (state == REQ);
    imem_req_addr  = pc;
  end

  // PC, output slot and hold buffer. The PC only advances when an instruction
  // enters the slot, so it also names the instruction in the hold buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_pc      <= 32'h0;
      if_instr   <= 32'h0;
      hold_data  <= 32'h0;
      misaligned <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= {redirect_pc[31:2], 2'b00};
      if_valid   <= 1'b0;
      hold_data  <= 32'h0;
      misaligned <= |redirect_pc[1:0];
    end else begin
      misaligned <= 1'b0;
      if (state == WAIT && imem_rsp_valid && slot_free) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= imem_rsp_data;
        pc       <= pc + 32'd4;
      end else if (state == WAIT && imem_rsp_valid) begin
        hold_data <= imem_rsp_data;
      end else if (state == HOLD && consume) begin
        if_valid  <= 1'b1;
        if_pc     <= pc;
        if_instr  <= hold_data;
        hold_data <= 32'h0;
        pc        <= pc + 32'd4;
      end else if (consume) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: memory handshake driven step by step with
// hand-computed expectations.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] pc;
  logic        misaligned;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .pc(pc), .misaligned(misaligned)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From REQ at addr: accept, respond one cycle later with addr+0x1000.
  task automatic fetch(input logic [31:0] addr);
    chk("req_addr", imem_req_addr, addr);
    chk("req_valid_req", {31'b0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("req_valid_wait", {31'b0, imem_req_valid}, 32'd0);
    chk("if_valid_gap", {31'b0, if_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = addr + 32'h1000;
    tick();
    imem_rsp_valid = 1'b0;
    chk("fill_valid", {31'b0, if_valid}, 32'd1);
    chk("fill_pc", if_pc, addr);
    chk("fill_instr", if_instr, addr + 32'h1000);
    chk("next_addr", imem_req_addr, addr + 32'd4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    rst = 1'b0;
    tick();

    // free run
    fetch(32'h0); fetch(32'h4); fetch(32'h8);

    // request to 0x4 held off by ready=0 for 3 cycles
    do_reset();
    fetch(32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("held_addr", imem_req_addr, 32'h4);
    end
    fetch(32'h4);

    // stall 6 cycles with 0x0 in the slot; 0x4 goes to the hold buffer
    do_reset();
    fetch(32'h0);
    stall = 1'b1; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("stall_slot_pc", if_pc, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1004;
    tick();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
      chk("hold_slot_pc", if_pc, 32'h0);
      chk("hold_slot_instr", if_instr, 32'h1000);
      chk("hold_pc", pc, 32'h4);
      tick();
    end
    stall = 1'b0;
    tick();
    chk("release_pc", if_pc, 32'h4);
    chk("release_instr", if_instr, 32'h1004);
    chk("release_valid", {31'b0, if_valid}, 32'd1);
    chk("release_req", imem_req_addr, 32'h8);

    // redirect to 0x100 while waiting on 0x8 (slot held by stall)
    stall = 1'b1; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; stall = 1'b0;
    chk("wait_slot_valid", {31'b0, if_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("redir_if_valid", {31'b0, if_valid}, 32'd0);
    chk("redir_pc", pc, 32'h100);
    chk("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
    chk("redir_mis", {31'b0, misaligned}, 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1008;
    tick();
    imem_rsp_valid = 1'b0;
    chk("drain_if_valid", {31'b0, if_valid}, 32'd0);
    fetch(32'h100);

    // misaligned redirect, issued while REQ is not accepted
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    tick();
    redirect_valid = 1'b0;
    chk("mis_pulse", {31'b0, misaligned}, 32'd1);
    chk("mis_if_valid", {31'b0, if_valid}, 32'd0);
    tick();
    chk("mis_clear", {31'b0, misaligned}, 32'd0);
    fetch(32'h200);

    // wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_mis", {31'b0, misaligned}, 32'd0);
    fetch(32'hFFFF_FFFC);
    fetch(32'h0);

    // redirect in the same cycle the request is accepted -> drain
    redirect_valid = 1'b1; redirect_pc = 32'h40; imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b0;
    chk("acc_redir_noreq", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0004;
    tick();
    imem_rsp_valid = 1'b0;
    chk("acc_redir_ifv", {31'b0, if_valid}, 32'd0);
    fetch(32'h40);

    // reset while waiting; the late response must be ignored
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("late_if_valid", {31'b0, if_valid}, 32'd0);
    chk("late_pc", pc, 32'h0);
    tick();
    chk("late_if_valid2", {31'b0, if_valid}, 32'd0);
    fetch(32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
